// File: rtl/sprite_pkg.sv
// Shared screen constants, colour type and the fixed 16-entry sprite palette.
package sprite_pkg;
  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int COLOR_BITS = 4;

  typedef struct packed {
    logic [COLOR_BITS-1:0] r;
    logic [COLOR_BITS-1:0] g;
    logic [COLOR_BITS-1:0] b;
  } rgb_t;

  // EGA-style palette; index 0 is black but is usually the transparent key.
  function automatic rgb_t pal_lookup(input logic [3:0] idx);
    rgb_t c;
    c = '0;
    case (idx)
      4'h0: c = 12'h000;
      4'h1: c = 12'h00A;
      4'h2: c = 12'h0A0;
      4'h3: c = 12'h0AA;
      4'h4: c = 12'hA00;
      4'h5: c = 12'hA0A;
      4'h6: c = 12'hA50;
      4'h7: c = 12'hAAA;
      4'h8: c = 12'h555;
      4'h9: c = 12'h55F;
      4'hA: c = 12'h5F5;
      4'hB: c = 12'h5FF;
      4'hC: c = 12'hF55;
      4'hD: c = 12'hF5F;
      4'hE: c = 12'hFF5;
      4'hF: c = 12'hFFF;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/sprite_frame_rom.sv
// Synchronous-read sprite texel ROM, one cycle read latency.
module sprite_frame_rom #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 4,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter     ROM_FILE = "sprite.mem"
) (
  input  logic              vga_clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge vga_clk) rdata <= mem[addr];
endmodule

// File: rtl/sprite_blitter.sv
// Animated, scaled, mirrorable sprite composited over a background layer.
// Three register stages: address (S1), ROM index (S2), composited colour (S3).
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int SCALE_LOG2 = 1,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 8,
  parameter int PAL_BITS   = 4,
  parameter int TRANSP_IDX = 0,
  parameter     ROM_FILE   = "sprite.mem"
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       blank,
  input  logic       frame_start,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       pos_valid,
  input  logic       anim_en,
  input  logic       flip_x,
  input  logic [3:0] bg_red,
  input  logic [3:0] bg_green,
  input  logic [3:0] bg_blue,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       hit,
  output logic [((NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1)-1:0] frame_idx
);
  localparam int TEX    = SPR_W * SPR_H;
  localparam int DEPTH  = NUM_FRAMES * TEX;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int SX_W   = $clog2(SPR_W);
  localparam int SY_W   = $clog2(SPR_H);
  localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int STAGES = 1;
  localparam logic signed [10:0] BOX_W = 11'(SPR_W << SCALE_LOG2);
  localparam logic signed [10:0] BOX_H = 11'(SPR_H << SCALE_LOG2);

  logic [9:0]         pend_x, pend_y, act_x, act_y;
  logic [DIV_W-1:0]   div_cnt;
  logic signed [10:0] dx, dy;
  logic               in_box;
  logic [SX_W-1:0]    sx;
  logic [SY_W-1:0]    sy;
  logic [ADDR_W-1:0]  addr, s1_addr;
  logic               s1_inside, s2_inside;
  rgb_t               s1_bg, s2_bg, pal;
  logic [STAGES:0]    vld_pipe;
  logic [PAL_BITS-1:0] rom_idx;

  // Offsets go negative left/above the sprite; positions past the screen never match.
  assign dx = $signed({1'b0, DrawX}) - $signed({1'b0, act_x});
  assign dy = $signed({1'b0, DrawY}) - $signed({1'b0, act_y});
  assign in_box = (dx >= 11'sd0) && (dx < BOX_W) && (dy >= 11'sd0) && (dy < BOX_H) &&
                  (DrawX < 10'(SCREEN_W)) && (DrawY < 10'(SCREEN_H));
  assign sx   = flip_x ? ~dx[SCALE_LOG2 +: SX_W] : dx[SCALE_LOG2 +: SX_W];
  assign sy   = dy[SCALE_LOG2 +: SY_W];
  assign addr = ADDR_W'(32'(frame_idx) * TEX + 32'({sy, sx}));
  assign pal  = pal_lookup(4'(rom_idx));

  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      pend_x    <= '0;
      pend_y    <= '0;
      act_x     <= '0;
      act_y     <= '0;
      div_cnt   <= '0;
      frame_idx <= '0;
    end else begin
      if (pos_valid) begin
        pend_x <= pos_x;
        pend_y <= pos_y;
      end
      if (frame_start) begin
        act_x <= pos_valid ? pos_x : pend_x;
        act_y <= pos_valid ? pos_y : pend_y;
        if (anim_en) begin
          if (32'(div_cnt) == FRAME_DIV - 1) begin
            div_cnt   <= '0;
            frame_idx <= (32'(frame_idx) == NUM_FRAMES - 1) ? '0 : frame_idx + 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      end
    end
  end

  sprite_frame_rom #(
    .DEPTH(DEPTH), .DATA_W(PAL_BITS), .ADDR_W(ADDR_W), .ROM_FILE(ROM_FILE)
  ) u_rom (
    .vga_clk(vga_clk), .addr(s1_addr), .rdata(rom_idx)
  );

  // vld_pipe carries active-video alongside the pixel; reset zeroes it to kill in-flight pixels.
  always_ff @(posedge vga_clk) begin
    if (!reset_n) begin
      vld_pipe  <= '0;
      s1_addr   <= '0;
      s1_inside <= 1'b0;
      s2_inside <= 1'b0;
      s1_bg     <= '0;
      s2_bg     <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      hit       <= 1'b0;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], blank};
      s1_addr   <= addr;
      s1_inside <= in_box;
      s1_bg     <= '{r: bg_red, g: bg_green, b: bg_blue};
      s2_inside <= s1_inside;
      s2_bg     <= s1_bg;
      if (!vld_pipe[STAGES]) begin
        {red, green, blue} <= '0;
        hit                <= 1'b0;
      end else if (s2_inside && rom_idx != PAL_BITS'(TRANSP_IDX)) begin
        {red, green, blue} <= {pal.r, pal.g, pal.b};
        hit                <= 1'b1;
      end else begin
        {red, green, blue} <= {s2_bg.r, s2_bg.g, s2_bg.b};
        hit                <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench: pixel stream vs. a screen-level model of the sprite layer.
module tb_sprite_blitter;
  localparam int SPR_W = 16, SPR_H = 16, SCALE_LOG2 = 1, NUM_FRAMES = 4;
  localparam int FRAME_DIV = 8, PAL_BITS = 4, TRANSP_IDX = 0;
  localparam int SCALE = 1 << SCALE_LOG2;

  logic       vga_clk = 1'b0, reset_n = 1'b0;
  logic [9:0] DrawX = '0, DrawY = '0, pos_x = '0, pos_y = '0;
  logic       blank = 1'b0, frame_start = 1'b0, pos_valid = 1'b0, anim_en = 1'b0, flip_x = 1'b0;
  logic [3:0] bg_red = '0, bg_green = '0, bg_blue = '0;
  logic [3:0] red, green, blue;
  logic       hit;
  logic [1:0] frame_idx;

  always #5 vga_clk = ~vga_clk;

  sprite_blitter #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .SCALE_LOG2(SCALE_LOG2), .NUM_FRAMES(NUM_FRAMES),
    .FRAME_DIV(FRAME_DIV), .PAL_BITS(PAL_BITS), .TRANSP_IDX(TRANSP_IDX), .ROM_FILE("")
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .anim_en(anim_en), .flip_x(flip_x), .bg_red(bg_red), .bg_green(bg_green),
    .bg_blue(bg_blue), .red(red), .green(green), .blue(blue), .hit(hit),
    .frame_idx(frame_idx)
  );

  logic [11:0] pal_m [16] = '{12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A,
                              12'hA50, 12'hAAA, 12'h555, 12'h55F, 12'h5F5, 12'h5FF,
                              12'hF55, 12'hF5F, 12'hFF5, 12'hFFF};
  int rom_m [NUM_FRAMES*SPR_W*SPR_H];
  int m_px, m_py, m_ax, m_ay, m_frame, m_div;
  logic [12:0] exp_q [$];
  int errors = 0, checks = 0;
  bit cur_flip = 1'b0, cur_ae = 1'b1;

  // Expected {rgb, hit} of one screen pixel given the sprite state it is sampled with.
  function automatic logic [12:0] model_pix(int x, int y, bit blk, bit flp, logic [11:0] bg);
    int dx, dy, sx, sy, idx;
    if (!blk) return '0;
    dx = x - m_ax;
    dy = y - m_ay;
    if (dx >= 0 && dx < SPR_W * SCALE && dy >= 0 && dy < SPR_H * SCALE) begin
      sx = dx / SCALE;
      sy = dy / SCALE;
      if (flp) sx = SPR_W - 1 - sx;
      idx = rom_m[m_frame * SPR_W * SPR_H + sy * SPR_W + sx];
      if (idx != TRANSP_IDX) return {pal_m[idx], 1'b1};
    end
    return {bg, 1'b0};
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  // One pixel clock: check the pixel from three clocks ago, then drive the next one.
  task automatic step(int x, int y, bit blk, bit flp, bit rst_n, bit pv, int px, int py,
                      bit fs, bit ae);
    logic [11:0] bg;
    logic [12:0] e, o;
    @(negedge vga_clk);
    if (exp_q.size() == 3) begin
      e = exp_q.pop_front();
      o = {red, green, blue, hit};
      checks++;
      assert (o === e) else begin
        errors++;
        $error("FAIL pixel obs=%h exp=%h", o, e);
      end
      checks++;
      assert (frame_idx === 2'(m_frame)) else begin
        errors++;
        $error("FAIL frame_idx obs=%0d exp=%0d", frame_idx, m_frame);
      end
    end
    bg = 12'($urandom);
    {bg_red, bg_green, bg_blue} = bg;
    DrawX = 10'(x); DrawY = 10'(y); blank = blk; flip_x = flp; reset_n = rst_n;
    pos_valid = pv; pos_x = 10'(px); pos_y = 10'(py); frame_start = fs; anim_en = ae;
    exp_q.push_back(model_pix(x, y, blk, flp, bg));
    if (!rst_n) begin
      foreach (exp_q[i]) exp_q[i] = '0;
      m_px = 0; m_py = 0; m_ax = 0; m_ay = 0; m_frame = 0; m_div = 0;
    end else begin
      if (fs) begin
        m_ax = pv ? px : m_px;
        m_ay = pv ? py : m_py;
        if (ae) begin
          if (m_div == FRAME_DIV - 1) begin
            m_div = 0;
            m_frame = (m_frame + 1) % NUM_FRAMES;
          end else m_div++;
        end
      end
      if (pv) begin m_px = px; m_py = py; end
    end
  endtask

  task automatic pix(int x, int y);
    step(x, y, 1'b1, cur_flip, 1'b1, 1'b0, 0, 0, 1'b0, cur_ae);
  endtask

  task automatic scan(int y, int x0, int x1);
    for (int x = x0; x <= x1; x++) pix(x, y);
  endtask

  task automatic ctl(bit pv, int px, int py, bit fs);
    step(0, 0, 1'b0, cur_flip, 1'b1, pv, px, py, fs, cur_ae);
  endtask

  task automatic set_tex(int f, int x, int y, int v);
    for (int i = 0; i < 3; i++) ctl(1'b0, 0, 0, 1'b0);
    rom_m[f * SPR_W * SPR_H + y * SPR_W + x] = v;
    dut.u_rom.mem[f * SPR_W * SPR_H + y * SPR_W + x] = 4'(v);
  endtask

  task automatic chk_frame(int e);
    @(posedge vga_clk);
    #1;
    checks++;
    assert (frame_idx === 2'(e)) else begin
      errors++;
      $error("FAIL anim_step obs=%0d exp=%0d", frame_idx, e);
    end
  endtask

  initial begin
    int lo, hi, r;
    for (int i = 0; i < NUM_FRAMES * SPR_W * SPR_H; i++) begin
      rom_m[i] = int'($urandom_range(0, 15));
      dut.u_rom.mem[i] = 4'(rom_m[i]);
    end
    rom_m[0] = 5; dut.u_rom.mem[0] = 4'd5;
    // Reset held during active video, then release and place the sprite.
    for (int i = 0; i < 5; i++) step(100 + i, 50, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    scan(0, 0, 40);
    ctl(1'b1, 100, 50, 1'b0);
    scan(50, 95, 105);
    ctl(1'b0, 0, 0, 1'b1);
    scan(50, 90, 140);
    for (int y = 48; y < 84; y += 5) scan(y, 98, 134);
    // Transparency and mirroring on the top-left texel.
    set_tex(0, 0, 0, TRANSP_IDX);
    set_tex(0, 15, 0, 3);
    cur_flip = 1'b1; scan(50, 98, 103);
    cur_flip = 1'b0; scan(50, 98, 103);
    cur_flip = 1'b1; scan(51, 128, 133);
    cur_flip = 1'b0;
    // Double-buffer: pending move waits for the frame boundary.
    ctl(1'b1, 200, 50, 1'b0);
    scan(50, 95, 135);
    ctl(1'b0, 0, 0, 1'b1);
    scan(50, 195, 235);
    ctl(1'b1, 300, 50, 1'b1);
    scan(50, 295, 335);
    ctl(1'b1, 400, 60, 1'b0);
    ctl(1'b1, 410, 70, 1'b0);
    ctl(1'b0, 0, 0, 1'b1);
    scan(70, 405, 445);
    // Animation from a clean reset: one step per FRAME_DIV pulses, then frozen.
    step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    cur_ae = 1'b1;
    for (int p = 1; p <= 32; p++) begin
      ctl(1'b0, 0, 0, 1'b1);
      chk_frame((p / FRAME_DIV) % NUM_FRAMES);
      pix(p % 32, p % 32);
    end
    ctl(1'b1, 0, 0, 1'b1);
    for (int p = 1; p <= 12; p++) ctl(1'b0, 0, 0, 1'b1);
    chk_frame(1);
    cur_ae = 1'b0;
    for (int p = 0; p < 10; p++) begin
      ctl(1'b0, 0, 0, 1'b1);
      chk_frame(1);
    end
    scan(5, 0, 33);
    // Clipping at the right/bottom edges and off-screen positions.
    ctl(1'b1, 632, 100, 1'b1);
    scan(100, 620, 639);
    ctl(1'b1, 620, 470, 1'b1);
    for (int y = 466; y < 480; y += 3) scan(y, 616, 639);
    ctl(1'b1, 700, 100, 1'b1);
    scan(100, 600, 639);
    ctl(1'b1, 100, 600, 1'b1);
    scan(479, 95, 140);
    // Blanking inside the sprite.
    ctl(1'b1, 100, 50, 1'b1);
    for (int x = 100; x < 110; x++) step(x, 52, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    scan(52, 100, 110);
    // Random mix of pixels, control pulses and occasional mid-line resets.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      lo = clampi(m_ax - 8, 0, 639);
      hi = clampi(m_ax + 40, 0, 639);
      if (m_ax > 639) begin lo = 560; hi = 639; end
      if (r < 2) step(lo, m_ay, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      else step(int'($urandom_range(lo, hi)), clampi(m_ay + int'($urandom_range(0, 44)) - 6, 0, 479),
                r > 10, 1'($urandom), 1'b1, r > 94 || r == 5,
                (r == 99) ? 640 + int'($urandom_range(0, 300)) : int'($urandom_range(0, 620)),
                int'($urandom_range(0, 470)), r > 96 || r == 6, 1'($urandom));
    end
    for (int i = 0; i < 3; i++) ctl(1'b0, 0, 0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
